// File: rtl/matvec_pkg.sv
// Shared types and constants for the matvec datapath (Q4.12 words, Q.12 accumulators).
package matvec_pkg;

   localparam int unsigned Q412_FRAC_BITS = 12;
   localparam int unsigned DATA_WIDTH     = 16;
   localparam int unsigned ACC_WIDTH      = 32;

   typedef logic signed [15:0] q412_t;
   typedef logic signed [31:0] acc_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } collector_state_t;

endpackage

// File: rtl/q_narrow.sv
// Combinational narrowing of one accumulator word: optional round-half-up
// arithmetic shift, then clamp (RESULT_SAT_EN defined) or two's-complement wrap.
module q_narrow
   import matvec_pkg::*;
#(
   parameter int unsigned IN_W  = ACC_WIDTH,
   parameter int unsigned OUT_W = DATA_WIDTH,
   parameter int unsigned SHIFT = 0
) (
   input  logic [IN_W-1:0]  x,
   output logic [OUT_W-1:0] y_c,
   output logic             sat_c
);

   // One guard bit so the rounding add cannot overflow.
   localparam int unsigned EXT_W = IN_W + 1;

   logic signed [EXT_W-1:0] x_ext;
   logic signed [EXT_W-1:0] rounded;
   logic signed [EXT_W-1:0] shifted;

   assign x_ext = signed'({x[IN_W-1], x});

   // Round-half-up only applies when bits are actually shifted out.
   generate
      if (SHIFT > 0) begin : g_round
         assign rounded = x_ext + (EXT_W'(1) << (SHIFT - 1));
      end else begin : g_no_round
         assign rounded = x_ext;
      end
   endgenerate

   assign shifted = rounded >>> SHIFT;

`ifdef RESULT_SAT_EN
   localparam logic signed [EXT_W-1:0] SAT_MAX =
      signed'({{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
   localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

   // Clamp to the signed OUT_W range and flag any clamp.
   always_comb begin
      y_c   = shifted[OUT_W-1:0];
      sat_c = 1'b0;
      if (shifted > SAT_MAX) begin
         y_c   = SAT_MAX[OUT_W-1:0];
         sat_c = 1'b1;
      end else if (shifted < SAT_MIN) begin
         y_c   = SAT_MIN[OUT_W-1:0];
         sat_c = 1'b1;
      end
   end
`else
   logic unused_hi;

   // Plain wrap: keep the low OUT_W bits, never flag saturation.
   always_comb begin
      y_c   = shifted[OUT_W-1:0];
      sat_c = 1'b0;
   end

   assign unused_hi = ^shifted[EXT_W-1:OUT_W];
`endif

endmodule

// File: rtl/matvec_result_collector.sv
// Collects matvec_multiplier row results, narrows them to Q4.12 and re-emits
// them as BANDWIDTH-word vector-write chunks for the next layer.
// Optional saturation instead of wrap: define RESULT_SAT_EN.
module matvec_result_collector
   import matvec_pkg::*;
#(
   parameter int unsigned MAX_ROWS   = 64,
   parameter int unsigned BANDWIDTH  = 16,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ACC_WIDTH  = 32,
   parameter int unsigned SHIFT      = 0
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic [$clog2(MAX_ROWS):0]            num_rows,
   input  logic [ACC_WIDTH-1:0]                 result_in,
   input  logic                                 result_valid,
   output logic                                 vector_write_enable,
   output logic [$clog2(MAX_ROWS)-1:0]          vector_base_addr,
   output logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] vector_in,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 sat_flag
);

   localparam int unsigned CNT_W  = $clog2(MAX_ROWS) + 1;
   localparam int unsigned ADDR_W = $clog2(MAX_ROWS);
   localparam int unsigned LANE_W = (BANDWIDTH > 1) ? $clog2(BANDWIDTH) : 1;

   typedef logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] chunk_t;

   collector_state_t  state_q, state_d;
   logic [CNT_W-1:0]  rows_exp_q, rows_exp_d;
   logic [CNT_W-1:0]  row_count_q, row_count_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   chunk_t            staging_q, staging_d;
   chunk_t            vec_q, vec_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              we_q, we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              sat_q, sat_d;

   logic [DATA_WIDTH-1:0] narrow_y_c;
   logic                  narrow_sat_c;
   logic                  last_lane_c;
   logic                  last_row_c;

   // Shift/round/saturate of the incoming result.
   q_narrow #(
      .IN_W  (ACC_WIDTH),
      .OUT_W (DATA_WIDTH),
      .SHIFT (SHIFT)
   ) u_q_narrow (
      .x     (result_in),
      .y_c   (narrow_y_c),
      .sat_c (narrow_sat_c)
   );

   assign last_lane_c = (lane_q == LANE_W'(BANDWIDTH - 1));
   assign last_row_c  = (CNT_W'(row_count_q + CNT_W'(1)) == rows_exp_q);

   // Next-state and datapath update; start takes priority over result_valid.
   always_comb begin
      state_d     = state_q;
      rows_exp_d  = rows_exp_q;
      row_count_d = row_count_q;
      lane_d      = lane_q;
      staging_d   = staging_q;
      vec_d       = vec_q;
      base_d      = base_q;
      we_d        = 1'b0;
      done_d      = done_q;
      sat_d       = sat_q;

      if (start) begin
         rows_exp_d  = num_rows;
         row_count_d = '0;
         lane_d      = '0;
         staging_d   = '0;
         sat_d       = 1'b0;
         if (num_rows == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
         end else begin
            state_d = ST_COLLECT;
            done_d  = 1'b0;
         end
      end else begin
         case (state_q)
            ST_COLLECT: begin
               if (result_valid) begin
                  staging_d[lane_q] = narrow_y_c;
                  row_count_d       = CNT_W'(row_count_q + CNT_W'(1));
                  lane_d            = LANE_W'(lane_q + LANE_W'(1));
                  sat_d             = sat_q | narrow_sat_c;
                  if (last_lane_c || last_row_c) begin
                     vec_d     = staging_d;
                     base_d    = ADDR_W'(row_count_q - CNT_W'(lane_q));
                     we_d      = 1'b1;
                     lane_d    = '0;
                     staging_d = '0;
                     if (last_row_c) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                     end
                  end
               end
            end
            ST_IDLE, ST_DONE: begin
               state_d = state_q;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d == ST_COLLECT);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rows_exp_q  <= '0;
         row_count_q <= '0;
         lane_q      <= '0;
         staging_q   <= '0;
         vec_q       <= '0;
         base_q      <= '0;
         we_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rows_exp_q  <= rows_exp_d;
         row_count_q <= row_count_d;
         lane_q      <= lane_d;
         staging_q   <= staging_d;
         vec_q       <= vec_d;
         base_q      <= base_d;
         we_q        <= we_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sat_q       <= sat_d;
      end
   end

   assign vector_write_enable = we_q;
   assign vector_base_addr    = base_q;
   assign vector_in           = vec_q;
   assign busy                = busy_q;
   assign done                = done_q;
   assign sat_flag            = sat_q;

endmodule

// File: tb/tb_matvec_result_collector.sv
// Directed bench for matvec_result_collector with BANDWIDTH=4, MAX_ROWS=64.
module tb_matvec_result_collector;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [6:0]  num_rows = '0;
   logic [31:0] result_in = '0;
   logic        result_valid = 1'b0;
   logic        vector_write_enable;
   logic [5:0]  vector_base_addr;
   logic [3:0][15:0] vector_in;
   logic        busy;
   logic        done;
   logic        sat_flag;

   int vectors = 0;
   int miscompares = 0;
   int strobes = 0;
   int s0;

   matvec_result_collector #(
      .MAX_ROWS   (64),
      .BANDWIDTH  (4),
      .DATA_WIDTH (16),
      .ACC_WIDTH  (32),
      .SHIFT      (0)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .start               (start),
      .num_rows            (num_rows),
      .result_in           (result_in),
      .result_valid        (result_valid),
      .vector_write_enable (vector_write_enable),
      .vector_base_addr    (vector_base_addr),
      .vector_in           (vector_in),
      .busy                (busy),
      .done                (done),
      .sat_flag            (sat_flag)
   );

   always #5 clk = ~clk;

   // Strobe counter sampled mid-cycle.
   always @(negedge clk) begin
      if (vector_write_enable) strobes <= strobes + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [6:0] n);
      start    = 1'b1;
      num_rows = n;
      step();
      start    = 1'b0;
   endtask

   task automatic push(input logic [31:0] v);
      result_in    = v;
      result_valid = 1'b1;
      step();
      result_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      step();
      step();
      check("rst_we",   64'(vector_write_enable), 64'd0);
      check("rst_vec",  64'(vector_in), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      #3 rst_n = 1'b1;
      step();

      // Exact values, one full chunk
      s0 = strobes;
      do_start(7'd4);
      check("t1_busy", 64'(busy), 64'd1);
      push(32'sd4096);
      push(-32'sd8192);
      push(32'sd12288);
      check("t1_we_early", 64'(vector_write_enable), 64'd0);
      push(32'sd20480);
      check("t1_we",   64'(vector_write_enable), 64'd1);
      check("t1_base", 64'(vector_base_addr), 64'd0);
      check("t1_vec",  64'(vector_in), {16'h5000, 16'h3000, 16'hE000, 16'h1000});
      check("t1_done", 64'(done), 64'd1);
      check("t1_sat",  64'(sat_flag), 64'd0);
      check("t1_busy_end", 64'(busy), 64'd0);
      step();
      check("t1_we_off", 64'(vector_write_enable), 64'd0);
      check("t1_hold", 64'(vector_in), {16'h5000, 16'h3000, 16'hE000, 16'h1000});
      check("t1_strobes", 64'(strobes - s0), 64'd1);

      // Saturation / wrap
      do_start(7'd4);
      check("t2_done_clr", 64'(done), 64'd0);
      push(32'sd4096);
      push(32'sd81920);
      push(-32'sd100000);
      push(32'sd32767);
      check("t2_we", 64'(vector_write_enable), 64'd1);
`ifdef RESULT_SAT_EN
      check("t2_vec", 64'(vector_in), {16'h7FFF, 16'h8000, 16'h7FFF, 16'h1000});
      check("t2_sat", 64'(sat_flag), 64'd1);
`else
      check("t2_vec", 64'(vector_in), {16'h7FFF, 16'h7960, 16'h4000, 16'h1000});
      check("t2_sat", 64'(sat_flag), 64'd0);
`endif
      step();

      // Partial final chunk with gaps
      s0 = strobes;
      do_start(7'd6);
      for (int i = 1; i <= 6; i++) begin
         push(32'(i));
         if (i == 4) begin
            check("t3_we1",   64'(vector_write_enable), 64'd1);
            check("t3_base1", 64'(vector_base_addr), 64'd0);
            check("t3_vec1",  64'(vector_in), {16'd4, 16'd3, 16'd2, 16'd1});
            check("t3_done1", 64'(done), 64'd0);
            check("t3_busy1", 64'(busy), 64'd1);
         end
         if (i == 6) begin
            check("t3_we2",   64'(vector_write_enable), 64'd1);
            check("t3_base2", 64'(vector_base_addr), 64'd4);
            check("t3_vec2",  64'(vector_in), {16'd0, 16'd0, 16'd6, 16'd5});
            check("t3_done2", 64'(done), 64'd1);
         end
         step();
         if (i == 4) check("t3_gap_we", 64'(vector_write_enable), 64'd0);
         step();
      end
      check("t3_strobes", 64'(strobes - s0), 64'd2);

      // Abort mid-collect; valid on the restart edge is ignored
      s0 = strobes;
      do_start(7'd4);
      push(32'd100);
      push(32'd200);
      result_in    = 32'd999;
      result_valid = 1'b1;
      do_start(7'd4);
      result_valid = 1'b0;
      push(32'd7);
      push(32'd8);
      push(32'd9);
      push(32'd10);
      check("t4_we",   64'(vector_write_enable), 64'd1);
      check("t4_base", 64'(vector_base_addr), 64'd0);
      check("t4_vec",  64'(vector_in), {16'd10, 16'd9, 16'd8, 16'd7});
      step();
      check("t4_strobes", 64'(strobes - s0), 64'd1);
      check("t4_done", 64'(done), 64'd1);

      // Zero rows
      s0 = strobes;
      do_start(7'd0);
      check("t5_done", 64'(done), 64'd1);
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_we",   64'(vector_write_enable), 64'd0);
      push(32'd55);
      step();
      check("t5_strobes", 64'(strobes - s0), 64'd0);

      // Asynchronous reset mid-collect
      do_start(7'd4);
      push(32'd1);
      push(32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("t6_vec",  64'(vector_in), 64'd0);
      check("t6_base", 64'(vector_base_addr), 64'd0);
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_done", 64'(done), 64'd0);
      check("t6_we",   64'(vector_write_enable), 64'd0);
      #3 rst_n = 1'b1;
      step();
      s0 = strobes;
      for (int i = 0; i < 4; i++) push(32'(i + 20));
      step();
      check("t6_ignored", 64'(strobes - s0), 64'd0);
      check("t6_idle_busy", 64'(busy), 64'd0);
      do_start(7'd4);
      push(32'd11);
      push(32'd12);
      push(32'd13);
      push(32'd14);
      check("t6_we",    64'(vector_write_enable), 64'd1);
      check("t6_vec2",  64'(vector_in), {16'd14, 16'd13, 16'd12, 16'd11});
      check("t6_base2", 64'(vector_base_addr), 64'd0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/matvec_result_collector.md
Name: matvec_result_collector

Overview:
- Consumer for the matvec_multiplier result stream (result_out / result_valid), one row result per valid pulse.
- Narrows each 32-bit Q.12 accumulator to a 16-bit Q4.12 word and packs BANDWIDTH words into a chunk.
- Emits each chunk over the same vector-write interface matvec_multiplier accepts (vector_write_enable / vector_base_addr / vector_in), so one layer's output vector loads directly into the next layer's multiplier.

Parameters:
- MAX_ROWS, 64: maximum result-vector length; must be a multiple of BANDWIDTH.
- BANDWIDTH, 16: words per emitted chunk.
- DATA_WIDTH, 16: output word width, Q4.12.
- ACC_WIDTH, 32: input result width.
- SHIFT, 0: extra arithmetic right shift applied before narrowing; round-half-up when SHIFT>0.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; clears state and latches num_rows
- num_rows  in  $clog2(MAX_ROWS)+1  results expected, 0..MAX_ROWS
- result_in  in  ACC_WIDTH  signed row result
- result_valid  in  1  result_in valid this cycle
- vector_write_enable  out  1  one-cycle chunk strobe
- vector_base_addr  out  $clog2(MAX_ROWS)  index of chunk word 0
- vector_in  out  BANDWIDTH x DATA_WIDTH  signed chunk words
- busy  out  1  high in COLLECT
- done  out  1  level; high from final chunk strobe until next start
- sat_flag  out  1  sticky; any word saturated since start

Behaviour:
- Reset values:
  - all outputs 0, vector_in all 0;
  - state IDLE, staging registers 0, row counter 0, lane index 0.
- States and transitions:
  - IDLE: wait for start; start -> COLLECT.
  - COLLECT: capture results until num_rows are received.
  - DONE: hold done=1; start -> COLLECT.
- On start in any state, at the next edge:
  - rows_expected <= num_rows;
  - row_count, lane and staging <= 0;
  - done and sat_flag <= 0;
  - next state COLLECT, or DONE with done=1 and no strobe if num_rows=0.
- Start mid-COLLECT aborts: the partial chunk is discarded and never emitted.
- result_valid in COLLECT:
  - staging[lane] <= narrow(result_in); lane++ and row_count++.
  - If lane reaches BANDWIDTH-1, or row_count+1 == rows_expected, the same edge also:
    - copies staging, including the word now arriving, into the vector_in registers;
    - drives vector_base_addr <= row_count - lane;
    - sets vector_write_enable <= 1 for exactly one cycle;
    - clears lane and staging.
- Strobe latency: vector_write_enable is high in the cycle after the edge that sampled the chunk's last result_valid.
- vector_in and vector_base_addr hold their values until the next strobe.
- A partial final chunk has its unused lanes at 0.
- The final chunk's strobe edge also sets done <= 1 and next state DONE.
- result_valid is ignored in IDLE and DONE, and on the start edge itself (start has priority).
- Back-to-back result_valid every cycle is supported with no stall.
- When BANDWIDTH=1, consecutive strobes are legal.
- narrow(x):
  - y = x >>> SHIFT, adding 1<<(SHIFT-1) before the shift when SHIFT>0;
  - then reduce to DATA_WIDTH bits (see Optional Feature).
- busy = (state == COLLECT).

Optional Feature:
- Macro RESULT_SAT_EN.
- Defined:
  - y is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1];
  - any clamp sets sat_flag (sticky until start).
- Undefined:
  - the low DATA_WIDTH bits of y are taken (two's-complement wrap);
  - sat_flag is tied 0.

Decomposition:
- Shared package matvec_pkg holds:
  - Q412_FRAC_BITS = 12, DATA_WIDTH, ACC_WIDTH;
  - typedef q412_t = logic signed [15:0];
  - typedef acc_t = logic signed [31:0];
  - collector state enum typedef.
- One sub-module, q_narrow: combinational shift/round/saturate of one word, instantiated once on result_in.

Test Plan:
- Exact values, BANDWIDTH=4, num_rows=4, results 4096, -8192, 12288, 20480 on consecutive cycles:
  - one strobe, cycle after the 4th valid, base 0;
  - vector_in = {4096, -8192, 12288, 20480}; done=1, sat_flag=0.
- Saturation, results 4096, 81920, -100000, 32767:
  - with RESULT_SAT_EN: {4096, 32767, -32768, 32767}, sat_flag=1;
  - without RESULT_SAT_EN: {4096, 16384, -34464 wrapped i.e. 31072, 32767}.
- Partial chunk, num_rows=6, valids spaced with 2-cycle gaps:
  - first strobe at base 0;
  - second strobe at base 4 with lanes 2..3 = 0; done asserts with the second strobe.
- Abort: start, 2 valid results, start again with num_rows=4, then 4 results:
  - exactly one strobe, containing only the last 4 results.
- num_rows=0: done=1 the cycle after start, vector_write_enable never asserts.
- Reset mid-COLLECT (rst_n low asynchronously after 2 results):
  - all outputs 0 immediately;
  - after release, result_valid is ignored until start.
